// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_scanner_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned VALUE_W = DIGITS * NIB_W;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    // One display buffer: everything captured by a load strobe.
    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [DIGITS-1:0]  dp;
        logic [DIGITS-1:0]  blink;
        logic               lz;
    } disp_buf_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Load-side payload and board-pin bundle of the seven-segment scanner.
interface seven_seg_scanner_if;
    import seven_seg_scanner_pkg::*;

    logic [VALUE_W-1:0] value;
    logic [DIGITS-1:0]  dp_in;
    logic [DIGITS-1:0]  blink_mask;
    logic               lz_suppress;
    logic               load;
    logic [DIGITS-1:0]  an;
    logic [SEG_W-1:0]   seg;
    logic               dp;
    logic               frame_done;

    modport master (
        output value, dp_in, blink_mask, lz_suppress, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, dp_in, blink_mask, lz_suppress, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode driver: blank/drive slot FSM, double-buffered
// load committed on frame boundaries, blink and leading-zero masking.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 20000000
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned SLOT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam int unsigned IDX_W   = $clog2(DIGITS);

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    disp_buf_t          pend_q, act_q, load_buf_c;
    logic               pend_valid_q;
    logic               boundary_c;
    logic [DIGITS-1:0]  shown_c;
    logic [NIB_W-1:0]   nibble_c;
    logic [SEG_W-1:0]   hex_seg_c;
    logic [DIGITS-1:0]  an_d;
    logic [SEG_W-1:0]   seg_d;
    logic               dp_d;

    always_comb begin
        load_buf_c.value = bus.value;
        load_buf_c.dp    = bus.dp_in;
        load_buf_c.blink = bus.blink_mask;
        load_buf_c.lz    = bus.lz_suppress;
    end

    // Digit i survives suppression if it or any higher nibble is nonzero, or its dp is lit.
    always_comb begin
        shown_c = '1;
        if (act_q.lz) begin
            for (int i = 1; i < DIGITS; i++) begin
                shown_c[i] = (|(act_q.value >> (i * NIB_W))) | act_q.dp[i];
            end
        end
    end

    assign nibble_c = act_q.value[idx_q * NIB_W +: NIB_W];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_c),
        .seg_c  (hex_seg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        idx_d      = idx_q;
        boundary_c = 1'b0;
        an_d       = '1;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b1;
        case (state_q)
            ST_BLANK: begin
                if (slot_cnt_q == SLOT_W'(BLANK_CYCLES - 1)) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (shown_c[idx_q] && !(blink_phase_q && act_q.blink[idx_q])) begin
                    an_d  = ~(DIGITS'(1) << idx_q);
                    seg_d = hex_seg_c;
                    dp_d  = ~act_q.dp[idx_q];
                end
                if (slot_cnt_q == SLOT_W'(REFRESH_DIV - 1)) begin
                    state_d    = ST_BLANK;
                    slot_cnt_d = '0;
                    idx_d      = idx_q + IDX_W'(1);
                    boundary_c = (idx_q == IDX_W'(DIGITS - 1));
                end
            end
        endcase
    end

    // Free-running blink timebase, independent of loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

    // A load on the boundary cycle bypasses pending so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            act_q        <= '0;
            pend_valid_q <= 1'b0;
        end else if (boundary_c) begin
            if (bus.load) begin
                act_q <= load_buf_c;
            end else if (pend_valid_q) begin
                act_q <= pend_q;
            end
            pend_valid_q <= 1'b0;
        end else if (bus.load) begin
            pend_q       <= load_buf_c;
            pend_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an         <= '1;
            bus.seg        <= SEG_BLANK;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= an_d;
            bus.seg        <= seg_d;
            bus.dp         <= dp_d;
            bus.frame_done <= boundary_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with a small refresh configuration.
module tb_seven_seg_scanner;

    localparam int unsigned REFRESH_DIV  = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned BLINK_DIV    = 64;
    localparam int          FRAME        = 32;

    typedef struct packed {
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cap_pos = 0;
    int   fd_cnt = 0;
    frame_t exp_q[$];
    frame_t cur;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst_n) fd_cnt = 0;
        else if (bus.frame_done === 1'b1) fd_cnt++;
    end

    // Monitor: after each frame_done, compare the next 32 pin samples against one expected frame.
    always @(negedge clk) begin : monitor
        int         slot;
        int         pos;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       efd;
        logic       slot_bad;
        logic [3:0] bad_an, bad_ean;
        logic [6:0] bad_seg, bad_eseg;
        logic       bad_dp, bad_edp, bad_fd, bad_efd;
        int         bad_pos;
        if (!rst_n) begin
            cap_pos = 0;
        end else begin
            if (cap_pos != 0) begin
                slot = (cap_pos - 1) / 8;
                pos  = (cap_pos - 1) % 8;
                efd  = (cap_pos == FRAME);
                if (pos < BLANK_CYCLES) begin
                    ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
                end else begin
                    ean = cur.an[slot]; eseg = cur.seg[slot]; edp = cur.dp[slot];
                end
                if (pos == 0) slot_bad = 1'b0;
                if (!slot_bad && (bus.an !== ean || bus.frame_done !== efd ||
                    ((ean != 4'hF || pos < BLANK_CYCLES) && (bus.seg !== eseg || bus.dp !== edp)))) begin
                    slot_bad = 1'b1;
                    bad_pos = pos;
                    bad_an = bus.an; bad_seg = bus.seg; bad_dp = bus.dp; bad_fd = bus.frame_done;
                    bad_ean = ean; bad_eseg = eseg; bad_edp = edp; bad_efd = efd;
                end
                if (pos == 7) begin
                    checks++;
                    if (slot_bad) begin
                        errors++;
                        $display("FAIL slot%0d cyc%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                                 slot, bad_pos, bad_an, bad_seg, bad_dp, bad_fd,
                                 bad_ean, bad_eseg, bad_edp, bad_efd);
                    end
                end
                if (cap_pos == FRAME) cap_pos = 0;
                else cap_pos++;
            end
            if (cap_pos == 0 && bus.frame_done === 1'b1 && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                cap_pos = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [3:0] vis, input logic [3:0] dpl);
        frame_t f;
        f.seg = {s3, s2, s1, s0};
        for (int k = 0; k < 4; k++) f.an[k] = vis[k] ? ~(4'b0001 << k) : 4'b1111;
        f.dp = ~dpl;
        exp_q.push_back(f);
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (bus.frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_done: frame_done=%b after timeout, required 1", bus.frame_done);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        bus.value = v; bus.dp_in = d; bus.blink_mask = b; bus.lz_suppress = lz;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || cap_pos != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || cap_pos != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d frames still pending, required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_an"}, 32'(bus.an), 32'hF);
        chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
        chk({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
    endtask

    task automatic check_release(input string tag);
        rst_n = 1'b1;
        @(negedge clk); chk({tag, "_blank0"}, 32'(bus.an), 32'hF);
        @(negedge clk); chk({tag, "_blank1"}, 32'(bus.an), 32'hF);
        @(negedge clk); chk({tag, "_first_digit"}, {21'd0, bus.an, bus.seg}, {21'd0, 4'b1110, 7'b1000000});
    endtask

    initial begin : stim
        int m;
        int n;
        bus.value = '0; bus.dp_in = '0; bus.blink_mask = '0; bus.lz_suppress = 1'b0; bus.load = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_pins("reset");
        @(negedge clk);
        @(negedge clk);
        check_release("release");

        // Hex word across all four digits.
        wait_fd();
        do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        push_exp(7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110, 4'b1111, 4'b0000);
        drain();

        // Decimal points on digits 1 and 3.
        wait_fd();
        do_load(16'h8B3D, 4'b1010, 4'b0000, 1'b0);
        push_exp(7'b0000000, 7'b0000011, 7'b0110000, 7'b0100001, 4'b1111, 4'b1010);
        drain();

        // Mid-drive reset blanks the pins at once and clears the active buffer.
        n = 0;
        @(negedge clk);
        while (bus.an === 4'hF && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_pins("mid_reset");
        @(negedge clk);
        @(negedge clk);
        check_release("re_release");

        // Leading-zero suppression cases.
        wait_fd();
        do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
        push_exp(7'h7F, 7'h7F, 7'b0110000, 7'b1000000, 4'b0011, 4'b0000);
        drain();
        wait_fd();
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        push_exp(7'h7F, 7'h7F, 7'h7F, 7'b1000000, 4'b0001, 4'b0000);
        drain();
        wait_fd();
        do_load(16'h0005, 4'b0100, 4'b0000, 1'b1);
        push_exp(7'h7F, 7'b1000000, 7'h7F, 7'b0010010, 4'b0101, 4'b0100);
        drain();
        wait_fd();
        do_load(16'h0700, 4'b0000, 4'b0000, 1'b1);
        push_exp(7'h7F, 7'b1111000, 7'b1000000, 7'b1000000, 4'b0111, 4'b0000);
        drain();

        // Two loads in one frame: only the later one is displayed.
        wait_fd();
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        push_exp(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'b1111, 4'b0000);
        drain();

        // Load exactly on the boundary cycle shows in the next frame.
        wait_fd();
        repeat (31) @(negedge clk);
        push_exp(7'b1000110, 7'b1000000, 7'b0100001, 7'b0000110, 4'b1111, 4'b0000);
        do_load(16'hC0DE, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Blink on digit 0: two frames visible, two frames hidden (64-cycle half period).
        wait_fd();
        do_load(16'h1234, 4'b0000, 4'b0001, 1'b0);
        m = fd_cnt;
        for (int f = m + 1; f <= m + 4; f++) begin
            push_exp(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                     ((f / 2) % 2 == 1) ? 4'b1110 : 4'b1111, 4'b0000);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
